grf_multiport: RTL
==================

# grf_multiport

Parametrised general-purpose register file: the successor to the two-read/one-write GRF in the pipelined MIPS core. It adds configurable data width, depth and read-port count, a second write port, a selectable same-cycle write-to-read bypass and a per-register pending scoreboard. It sits in the ID stage: reads feed the operand muxes, write port A is driven by WB and write port B by a secondary writeback path (e.g. the MDU). Issue marks let the hazard unit stall on registers with an in-flight producer.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers
- N_RD, 2: number of read ports, 1..4
- ZERO_REG, 1: 1 = register 0 is hard-wired to zero and is never pending
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers and pending bits
- rd_addr  in  N_RD*ADDR_W  read addresses; port k is slice [k*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  N_RD  the addressed register has an outstanding producer
- wa_en, wa_addr, wa_data  in  1 / ADDR_W / DATA_W  write port A (higher priority)
- wb_en, wb_addr, wb_data  in  1 / ADDR_W / DATA_W  write port B
- iss_en, iss_addr  in  1 / ADDR_W  mark iss_addr pending (a producer has issued)
- pend_vec  out  DEPTH  registered pending bits, bit i = register i

## Operation
- **Storage.** DEPTH x DATA_W array plus a DEPTH-bit pending vector.
- **Reads.** Reads are combinational. With BYPASS=1, each port checks for an address match against an enabled write, in priority order port A, then port B, then the array. With BYPASS=0, each port returns the array value only.
- **Writes.** Writes occur on the rising clock edge.
  - A write with en=1 stores the data and clears the pending bit for that address.
  - If wa_addr == wb_addr and both writes are enabled, port A's data is stored and port B is dropped for that address.
- **Issue.** When iss_en=1, the pending bit for iss_addr is set on the clock edge.
  - If the same edge also writes iss_addr, the issue wins: the data is stored and the pending bit ends at 1, for the new producer.
- **Zero register (ZERO_REG=1).** Register 0:
  - reads 0 on every port, with no bypass;
  - ignores writes and issue;
  - always reports rd_busy=0, and pend_vec[0] is always 0.
- **rd_busy.** rd_busy[k] = pend[addr_k], masked by any enabled write to addr_k this cycle when BYPASS=1. An issue in the same cycle does not affect rd_busy until the next cycle.
- **Illegal N_RD.** An N_RD value outside 1..4 is an elaboration error.

## Timing
- **Read latency.** Reads have 0-cycle latency.
- **Write visibility.** A write is visible in the array on the cycle after its edge. With BYPASS=1 it is visible on read ports in the same cycle.
- **Reset values.**
  - Assertion of reset asynchronously forces every register and every pending bit to 0.
  - On the next evaluation, rd_data = 0 and rd_busy = 0 for all ports, and pend_vec = 0.
  - Writes and issues presented while reset is high are discarded.
- **Reset release.** Release is synchronised outside this block. The first edge with reset low performs normal writes and issues.
- **Back-to-back operations.** Issue and write of the same register on consecutive cycles need no idle cycle in between.

## Structure
- **Package grf_pkg.**
  - Default parameter constants: DATA_W, ADDR_W, N_RD.
  - REG_ZERO address constant.
  - Function that extracts slice k of a packed address or data bus.
- **Sub-module grf_read_port.** One instance per read port, generated N_RD times. It holds the address compare against both write ports, the bypass priority mux, zero forcing and the rd_busy masking.
- **Top level.** Holds the array, the pending vector, write arbitration and issue logic.

## Test plan
- **Reset.** Write 0xDEADBEEF to r5 and issue r6, then assert reset mid-cycle -> rd_data(r5) = 0 and pend_vec = 0 immediately, before any clock edge.
- **Bypass and priority.** BYPASS=1, wa: r3 = 0x11111111 and wb: r3 = 0x22222222 in the same cycle, read r3 -> 0x11111111 that cycle and 0x11111111 from the array on the next cycle.
- **No bypass.** BYPASS=0, write r7 = 0x12345678 -> read r7 returns the old value 0 that cycle and 0x12345678 on the next cycle.
- **Scoreboard.**
  - Issue r9 -> pend_vec[9] = 1 and rd_busy = 1 next cycle.
  - wb write to r9 while iss_en r9 in the same cycle -> pend_vec[9] stays 1.
  - A later plain write clears it.
- **Zero register.** ZERO_REG=1, write r0 = 0xFFFFFFFF and issue r0 -> reads 0 on all ports, rd_busy = 0, pend_vec[0] = 0.
- **Four read ports.** N_RD=4, DATA_W=64, ADDR_W=6, four distinct addresses including r63 -> each port returns its own value, with no cross-port aliasing.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the multiport general-purpose register file.
package grf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_N_RD   = 2;

    localparam int REG_ZERO = 0;

    // Widest packed bus the slice helper handles (4 ports x 64 bits).
    localparam int BUS_MAX = 256;

    function automatic logic [BUS_MAX-1:0] bus_slice(logic [BUS_MAX-1:0] bus, int k, int w);
        logic [BUS_MAX-1:0] mask;
        mask = (BUS_MAX'(1) << w) - BUS_MAX'(1);
        return (bus >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/grf_multiport_if.sv
// Read, write, issue and scoreboard signals of the register file.
interface grf_multiport_if import grf_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N_RD   = DEF_N_RD
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD*DATA_W-1:0] rd_data;
    logic [N_RD-1:0]        rd_busy;

    logic                   wa_en;
    logic [ADDR_W-1:0]      wa_addr;
    logic [DATA_W-1:0]      wa_data;

    logic                   wb_en;
    logic [ADDR_W-1:0]      wb_addr;
    logic [DATA_W-1:0]      wb_data;

    logic                   iss_en;
    logic [ADDR_W-1:0]      iss_addr;

    logic [DEPTH-1:0]       pend_vec;

    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr,
        input  rd_data, rd_busy, pend_vec
    );

    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr,
        output rd_data, rd_busy, pend_vec
    );

endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: write-port bypass, zero-register forcing and busy masking.
module grf_read_port import grf_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] arr_data,
    input  logic              pend_bit,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic              busy
);
    logic hit_a;
    logic hit_b;
    logic is_zero;

    assign hit_a   = (BYPASS != 0) && wa_en && (wa_addr == addr);
    assign hit_b   = (BYPASS != 0) && wb_en && (wb_addr == addr);
    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));

    always_comb begin
        data = arr_data;
        busy = pend_bit;
        if (hit_a) begin
            data = wa_data;
        end else if (hit_b) begin
            data = wb_data;
        end
        // A write landing this cycle retires the producer the reader would wait on.
        if (hit_a || hit_b) begin
            busy = 1'b0;
        end
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/grf_multiport.sv
// Parametrised register file: N_RD read ports, two write ports (A wins) and a pending scoreboard.
module grf_multiport import grf_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_RD     = DEF_N_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          reset,
    grf_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    if (N_RD < 1 || N_RD > 4) begin : g_bad_nrd
        $error("grf_multiport: N_RD must be in 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_next;
    logic              wa_ok;
    logic              wb_ok;
    logic              iss_ok;

    function automatic logic is_zero(logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
    endfunction

    assign wa_ok  = bus.wa_en && !is_zero(bus.wa_addr);
    // Port B is dropped outright when port A targets the same register.
    assign wb_ok  = bus.wb_en && !is_zero(bus.wb_addr) &&
                    !(bus.wa_en && (bus.wa_addr == bus.wb_addr));
    assign iss_ok = bus.iss_en && !is_zero(bus.iss_addr);

    // Issue is applied last so a new producer outlives a retiring write.
    always_comb begin
        pend_next = pend;
        if (wb_ok) begin
            pend_next[bus.wb_addr] = 1'b0;
        end
        if (wa_ok) begin
            pend_next[bus.wa_addr] = 1'b0;
        end
        if (iss_ok) begin
            pend_next[bus.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (wb_ok) begin
                mem[bus.wb_addr] <= bus.wb_data;
            end
            if (wa_ok) begin
                mem[bus.wa_addr] <= bus.wa_data;
            end
            pend <= pend_next;
        end
    end

    logic [N_RD-1:0][DATA_W-1:0] rd_data_k;
    logic [N_RD-1:0]             rd_busy_k;

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] arr;

        assign addr = ADDR_W'(bus_slice(BUS_MAX'(bus.rd_addr), k, ADDR_W));
        assign arr  = mem[addr];

        grf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr     (addr),
            .arr_data (arr),
            .pend_bit (pend[addr]),
            .wa_en    (bus.wa_en),
            .wa_addr  (bus.wa_addr),
            .wa_data  (bus.wa_data),
            .wb_en    (bus.wb_en),
            .wb_addr  (bus.wb_addr),
            .wb_data  (bus.wb_data),
            .data     (rd_data_k[k]),
            .busy     (rd_busy_k[k])
        );
    end

    assign bus.rd_data  = rd_data_k;
    assign bus.rd_busy  = rd_busy_k;
    assign bus.pend_vec = pend;

endmodule
